dino_motion_ctrl: RTL and testbench

//  Game-state and jump-physics sequencer for the dinosaur sprite. Owns the sprite Y

---
 rtl/dino_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_ctrl.sv
// Dinosaur game-state and jump-physics sequencer: owns sprite Y, velocity,
// the IDLE/RUN/RISE/FALL/DUCK/DEAD state machine and the survival score.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   tick_i       physics time base (level); only its rising edge is used
//   jump_req_i   one-cycle jump/start pulse
//   duck_i       duck key held (level)
//   hit_i        collision flag (level)
//   restart_i    one-cycle pulse that leaves DEAD
//   dino_y_o     sprite top-left Y
//   state_o      0 IDLE, 1 RUN, 2 RISE, 3 FALL, 4 DUCK, 5 DEAD
//   airborne_o   state is RISE or FALL
//   game_over_o  state is DEAD
//   score_o      ticks survived, saturating
module dino_motion_ctrl #(
  parameter logic [8:0] GROUND_Y = 9'd240,
  parameter logic [5:0] JUMP_V0  = 6'd16,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [5:0] MAX_V    = 6'd31
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        jump_req_i,
  input  logic        duck_i,
  input  logic        hit_i,
  input  logic        restart_i,
  output logic [8:0]  dino_y_o,
  output logic [2:0]  state_o,
  output logic        airborne_o,
  output logic        game_over_o,
  output logic [15:0] score_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_RISE = 3'd2,
    S_FALL = 3'd3,
    S_DUCK = 3'd4,
    S_DEAD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  y_q, y_d;
  logic [5:0]  vel_q, vel_d;
  logic [15:0] score_q, score_d;
  logic        tick_q;

  logic        tk;
  logic [6:0]  g_w;
  logic [6:0]  vsum;
  logic [5:0]  vn;
  logic [9:0]  ysum;

  assign tk   = tick_i & ~tick_q;

  // Holding duck while falling doubles gravity (fast drop).
  assign g_w  = duck_i ? {GRAVITY, 1'b0}
                       : {1'b0, GRAVITY};
  assign vsum = {1'b0, vel_q} + g_w;
  assign vn   = (vsum > {1'b0, MAX_V}) ? MAX_V
                                       : vsum[5:0];
  // One spare bit so the landing test cannot wrap.
  assign ysum = {1'b0, y_q} + {4'd0, vn};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      y_q     <= GROUND_Y;
      vel_q   <= '0;
      score_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      tick_q  <= tick_i;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (jump_req_i) state_d = S_RUN;
      end
      S_DEAD: begin
        if (restart_i) begin
          state_d = S_IDLE;
          y_d     = GROUND_Y;
          vel_d   = '0;
          score_d = '0;
        end
      end
      S_RUN, S_RISE, S_FALL, S_DUCK: begin
        if (hit_i) begin
          // Collision freezes everything for this cycle.
          state_d = S_DEAD;
        end else begin
          if (tk && score_q != 16'hFFFF)
            score_d = score_q + 16'd1;
          unique case (state_q)
            S_RUN: begin
              if (jump_req_i) begin
                state_d = S_RISE;
                vel_d   = JUMP_V0;
              end else if (duck_i) begin
                state_d = S_DUCK;
              end
            end
            S_DUCK: begin
              if (!duck_i) state_d = S_RUN;
            end
            S_RISE: begin
              if (tk) begin
                if ({3'd0, vel_q} > y_q) begin
                  // Top-of-screen clamp.
                  y_d     = '0;
                  vel_d   = '0;
                  state_d = S_FALL;
                end else begin
                  y_d = y_q - {3'd0, vel_q};
                  if (vel_q <= GRAVITY) begin
                    vel_d   = '0;
                    state_d = S_FALL;
                  end else begin
                    vel_d = vel_q - GRAVITY;
                  end
                end
              end
            end
            default: begin
              if (tk) begin
                if (ysum >= {1'b0, GROUND_Y}) begin
                  y_d     = GROUND_Y;
                  vel_d   = '0;
                  state_d = duck_i ? S_DUCK : S_RUN;
                end else begin
                  y_d   = ysum[8:0];
                  vel_d = vn;
                end
              end
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    state_o     = state_q;
    dino_y_o    = y_q;
    score_o     = score_q;
    airborne_o  = (state_q == S_RISE) ||
                  (state_q == S_FALL);
    game_over_o = (state_q == S_DEAD);
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed self-checking bench for dino_motion_ctrl.
// Instance A uses default physics; instance B uses a tall jump on a low floor.
module tb_dino_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        jump_a = 1'b0;
  logic        jump_b = 1'b0;
  logic        duck = 1'b0;
  logic        hit = 1'b0;
  logic        restart = 1'b0;

  logic [8:0]  ya, yb;
  logic [2:0]  sa, sb;
  logic        aira, airb;
  logic        goa, gob;
  logic [15:0] sca, scb;

  int n_cmp = 0;
  int n_err = 0;
  int maxb  = 0;

  always #5 clk = ~clk;

  dino_motion_ctrl dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .jump_req_i  (jump_a),
    .duck_i      (duck),
    .hit_i       (hit),
    .restart_i   (restart),
    .dino_y_o    (ya),
    .state_o     (sa),
    .airborne_o  (aira),
    .game_over_o (goa),
    .score_o     (sca)
  );

  dino_motion_ctrl #(
    .GROUND_Y (9'd100),
    .JUMP_V0  (6'd40)
  ) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .jump_req_i  (jump_b),
    .duck_i      (duck),
    .hit_i       (hit),
    .restart_i   (restart),
    .dino_y_o    (yb),
    .state_o     (sb),
    .airborne_o  (airb),
    .game_over_o (gob),
    .score_o     (scb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic jmp_a();
    @(negedge clk) jump_a = 1'b1;
    @(negedge clk) jump_a = 1'b0;
  endtask

  task automatic jmp_b();
    @(negedge clk) jump_b = 1'b1;
    @(negedge clk) jump_b = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(sa), 0);
    chk("rst_y", 32'(ya), 240);
    chk("rst_score", 32'(sca), 0);
    chk("rst_air", 32'(aira), 0);
    chk("rst_go", 32'(goa), 0);

    // IDLE ignores hit and ticks
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    chk("idle_hit", 32'(sa), 0);
    tk(2);
    chk("idle_score", 32'(sca), 0);

    // B: tall jump clamps at top, then falls to floor 100
    jmp_b();
    jmp_b();
    chk("b_rise", 32'(sb), 2);
    for (int i = 0; i < 3; i++) begin
      tk(1);
      if (yb > maxb) maxb = yb;
    end
    chk("b_clamp_y", 32'(yb), 0);
    chk("b_clamp_st", 32'(sb), 3);
    for (int i = 0; i < 13; i++) begin
      tk(1);
      if (yb > maxb) maxb = yb;
    end
    chk("b_fall13_y", 32'(yb), 91);
    tk(1);
    if (yb > maxb) maxb = yb;
    chk("b_land_y", 32'(yb), 100);
    chk("b_land_st", 32'(sb), 1);
    chk("b_nowrap", 32'(maxb), 100);
    chk("b_score", 32'(scb), 17);
    chk("a_still_idle", 32'(sa), 0);

    // A: full default jump
    jmp_a();
    chk("a_run", 32'(sa), 1);
    jmp_a();
    chk("a_rise", 32'(sa), 2);
    chk("a_air", 32'(aira), 1);
    tk(1);
    chk("a_y1", 32'(ya), 224);
    jmp_a();
    chk("a_jmp_ign_st", 32'(sa), 2);
    chk("a_jmp_ign_y", 32'(ya), 224);
    tk(15);
    chk("a_apex_y", 32'(ya), 104);
    chk("a_apex_st", 32'(sa), 3);
    tk(16);
    chk("a_land_y", 32'(ya), 240);
    chk("a_land_st", 32'(sa), 1);
    chk("a_land_air", 32'(aira), 0);
    chk("a_score32", 32'(sca), 32);

    // duck / ignore jump / release
    @(negedge clk) duck = 1'b1;
    @(negedge clk);
    chk("duck_st", 32'(sa), 4);
    jmp_a();
    chk("duck_jmp", 32'(sa), 4);
    chk("duck_y", 32'(ya), 240);
    @(negedge clk) duck = 1'b0;
    @(negedge clk);
    chk("unduck", 32'(sa), 1);

    // hit mid-rise with a simultaneous tick
    jmp_a();
    tk(3);
    chk("r3_y", 32'(ya), 195);
    chk("r3_score", 32'(sca), 35);
    @(negedge clk) begin
      tick = 1'b1;
      hit  = 1'b1;
    end
    @(negedge clk) begin
      tick = 1'b0;
      hit  = 1'b0;
    end
    chk("dead_st", 32'(sa), 5);
    chk("dead_y", 32'(ya), 195);
    chk("dead_score", 32'(sca), 35);
    chk("dead_go", 32'(goa), 1);
    jmp_a();
    tk(1);
    chk("dead_hold", 32'(sa), 5);
    chk("dead_yhold", 32'(ya), 195);
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk("rs_st", 32'(sa), 0);
    chk("rs_y", 32'(ya), 240);
    chk("rs_score", 32'(sca), 0);

    // fast drop while ducking
    jmp_a();
    jmp_a();
    tk(16);
    chk("fd_apex", 32'(ya), 104);
    duck = 1'b1;
    tk(11);
    chk("fd_y11", 32'(ya), 236);
    chk("fd_st11", 32'(sa), 3);
    tk(1);
    chk("fd_land_y", 32'(ya), 240);
    chk("fd_land_st", 32'(sa), 4);
    chk("fd_score", 32'(sca), 28);
    @(negedge clk) duck = 1'b0;
    @(negedge clk);
    chk("fd_run", 32'(sa), 1);

    // tick held high counts once
    @(negedge clk) tick = 1'b1;
    repeat (1000) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("hold_score", 32'(sca), 29);

    // reset mid-fall
    jmp_a();
    tk(19);
    chk("mf_y", 32'(ya), 110);
    chk("mf_st", 32'(sa), 3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("mr_st", 32'(sa), 0);
    chk("mr_y", 32'(ya), 240);
    chk("mr_score", 32'(sca), 0);
    chk("mr_air", 32'(aira), 0);
    chk("mr_b_y", 32'(yb), 100);
    chk("mr_b_score", 32'(scb), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
